lis3dh_ctrl: RTL
================

Name: lis3dh_ctrl

Overview:
Transaction sequencer directly upstream of the LIS3DH SPI master. After reset it waits out sensor boot, writes CTRL_REG1 and CTRL_REG4, and checks WHO_AM_I. It then periodically issues 16-bit burst reads of the X/Y/Z output register pairs and presents one assembled 3-axis sample with a valid strobe to downstream logic.

Parameters:
BOOT_CYCLES, 5000, clk cycles to wait after reset before the first transaction
SAMPLE_DIV, 500000, clk cycles between sample-read starts, measured start to start; must be >= 3*TIMEOUT
TIMEOUT, 4096, max clk cycles to wait for spi_done per transaction
CTRL1_VAL, 8'h57, byte written to CTRL_REG1 (addr 6'h20)
CTRL4_VAL, 8'h08, byte written to CTRL_REG4 (addr 6'h23)
WHO_AM_I_VAL, 8'h33, expected WHO_AM_I (addr 6'h0F) value

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
en  in  1  enables periodic sampling; configuration runs regardless
spi_rd  out  1  one-cycle read request to the SPI master
spi_wr  out  1  one-cycle write request to the SPI master
spi_addr  out  6  register address, held stable from the request until done
spi_data_tx  out  8  write data, held stable from the request until done
spi_data_rx  in  16  read data: [15:8] = byte at addr, [7:0] = byte at addr+1
spi_done  in  1  one-cycle pulse when the SPI master finishes a transaction
x_out, y_out, z_out  out  16 each  latest sample, {byte at addr+1, byte at addr}
sample_valid  out  1  one-cycle pulse when x/y/z_out update
cfg_done  out  1  high once configuration and the ID check pass
id_err  out  1  sticky: WHO_AM_I mismatch
timeout_err  out  1  sticky: spi_done missing within TIMEOUT

Behaviour:
- Reset (async assert, sync release): every output 0, including spi_rd, spi_wr, spi_addr, spi_data_tx, x/y/z_out and all flags. State = BOOT. Reset mid-transaction abandons it; the first request after release comes only after BOOT_CYCLES.
- States: BOOT -> WR1 -> WR4 -> RDID -> IDLE <-> RDX -> RDY -> RDZ -> PUB -> IDLE; ERR is terminal until reset.
- BOOT: count BOOT_CYCLES clocks, then go to WR1.
- Each transaction state has an ISSUE cycle and a WAIT phase:
  - ISSUE: drive spi_addr and spi_data_tx; pulse spi_wr (WR1, WR4) or spi_rd (RDID, RDX, RDY, RDZ) for exactly one cycle.
  - WAIT: hold addr and data; clear the timeout counter at ISSUE.
  - spi_done in WAIT: advance next cycle.
  - TIMEOUT cycles without spi_done: set timeout_err, go to ERR.
  - spi_done outside WAIT is ignored. rd and wr are never both high.
- Addresses: WR1 0x20 with CTRL1_VAL; WR4 0x23 with CTRL4_VAL; RDID 0x0F; RDX 0x28; RDY 0x2A; RDZ 0x2C. spi_data_tx = 0 for reads.
- RDID done: compare spi_data_rx[15:8] to WHO_AM_I_VAL.
  - Mismatch: id_err=1, go to ERR.
  - Match: cfg_done=1, go to IDLE.
- IDLE: a free-running period counter, started when IDLE is first entered, wraps every SAMPLE_DIV cycles. At wrap with en=1, go to RDX. With en=0 the wrap is skipped with no catch-up.
- RDX/RDY/RDZ done: latch spi_data_rx into a shadow register, byte-swapped to {rx[7:0], rx[15:8]}.
- PUB (one cycle): copy all three shadows to x/y/z_out together and pulse sample_valid. Outputs never show a partial sample.
- en deasserted mid-sample: the current X/Y/Z sequence completes and publishes.
- ERR: no requests; cfg_done=0; error flags hold.
- spi_done in the same cycle as the timeout expiry counts as done, not timeout.

Test Plan:
1. Reset, SPI model answers each request with done after 40 cycles and WHO_AM_I=8'h33 -> writes (0x20,0x57) then (0x23,0x08), read 0x0F; cfg_done=1 after the third done; each rd/wr pulse exactly 1 cycle wide.
2. en=1; model returns 16'h3412, 16'hCDAB, 16'h0080 for 0x28/0x2A/0x2C -> x_out=16'h1234, y_out=16'hABCD, z_out=16'h8000; single sample_valid pulse; next RDX starts exactly SAMPLE_DIV cycles after the previous one.
3. WHO_AM_I returns 8'h32 -> id_err=1, cfg_done=0, no further rd/wr pulses for 10*SAMPLE_DIV cycles.
4. Model never raises done on the RDY request -> timeout_err=1 exactly TIMEOUT cycles after ISSUE; x/y/z_out keep their prior values; no sample_valid.
5. reset asserted mid-RDY, then released -> all outputs 0 immediately; no request for BOOT_CYCLES; full configuration replays.
6. en dropped during RDX -> that sample still publishes; no RDX at the following period wraps until en=1 again.

Source files
------------

// File: rtl/lis3dh_ctrl.sv
// LIS3DH transaction sequencer: boot wait, CTRL_REG1/CTRL_REG4 writes, WHO_AM_I
// check, then periodic X/Y/Z burst reads published as one atomic 3-axis sample.
module lis3dh_ctrl #(
  parameter int         BOOT_CYCLES  = 5000,
  parameter int         SAMPLE_DIV   = 500000,
  parameter int         TIMEOUT      = 4096,
  parameter logic [7:0] CTRL1_VAL    = 8'h57,
  parameter logic [7:0] CTRL4_VAL    = 8'h08,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic        spi_rd,
  output logic        spi_wr,
  output logic [5:0]  spi_addr,
  output logic [7:0]  spi_data_tx,
  input  logic [15:0] spi_data_rx,
  input  logic        spi_done,
  output logic [15:0] x_out,
  output logic [15:0] y_out,
  output logic [15:0] z_out,
  output logic        sample_valid,
  output logic        cfg_done,
  output logic        id_err,
  output logic        timeout_err,
  output logic [3:0]  dbg_state_o
);

  // SPI handshake: spi_rd/spi_wr is a one-cycle request; spi_addr/spi_data_tx stay
  // stable until the one-cycle spi_done pulse, which is honoured only while waiting.
  typedef enum logic [3:0] {BOOT, WR1, WR4, RDID, IDLE, RDX, RDY, RDZ, PUB, ERR} state_t;

  state_t      state_q, state_d, nxt;
  logic        issue_q, issue_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] per_q, per_d;
  logic        per_run_q, per_run_d;
  logic [15:0] shx_q, shx_d, shy_q, shy_d, shz_q, shz_d;
  logic [15:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic        sv_q, sv_d, cfg_q, cfg_d, id_err_q, id_err_d, tmo_err_q, tmo_err_d;
  logic        txn, txn_rd, wrap;
  logic [15:0] rx_swap;

  assign wrap    = per_run_q && (per_q == 32'(SAMPLE_DIV - 1));
  assign rx_swap = {spi_data_rx[7:0], spi_data_rx[15:8]};

  always_comb begin
    state_d     = state_q;
    nxt         = state_q;
    issue_d     = 1'b0;
    cnt_d       = cnt_q;
    per_run_d   = per_run_q;
    per_d       = per_run_q ? (wrap ? 32'd0 : per_q + 32'd1) : per_q;
    shx_d       = shx_q;
    shy_d       = shy_q;
    shz_d       = shz_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    sv_d        = 1'b0;
    cfg_d       = cfg_q;
    id_err_d    = id_err_q;
    tmo_err_d   = tmo_err_q;
    spi_rd      = 1'b0;
    spi_wr      = 1'b0;
    spi_addr    = 6'h00;
    spi_data_tx = 8'h00;
    txn         = 1'b1;
    txn_rd      = 1'b1;

    unique case (state_q)
      BOOT: begin
        txn = 1'b0;
        if (cnt_q == 32'(BOOT_CYCLES - 1)) begin
          state_d = WR1;
          issue_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WR1:  begin txn_rd = 1'b0; spi_addr = 6'h20; spi_data_tx = CTRL1_VAL; nxt = WR4; end
      WR4:  begin txn_rd = 1'b0; spi_addr = 6'h23; spi_data_tx = CTRL4_VAL; nxt = RDID; end
      RDID: begin
        spi_addr = 6'h0F;
        nxt      = (spi_data_rx[15:8] == WHO_AM_I_VAL) ? IDLE : ERR;
      end
      IDLE: begin
        txn = 1'b0;
        // Wraps seen with en low are simply dropped; no sample is owed later.
        if (wrap && en) begin
          state_d = RDX;
          issue_d = 1'b1;
        end
      end
      RDX:  begin spi_addr = 6'h28; nxt = RDY; end
      RDY:  begin spi_addr = 6'h2A; nxt = RDZ; end
      RDZ:  begin spi_addr = 6'h2C; nxt = PUB; end
      PUB: begin
        txn     = 1'b0;
        x_d     = shx_q;
        y_d     = shy_q;
        z_d     = shz_q;
        sv_d    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        txn       = 1'b0;
        cfg_d     = 1'b0;
        per_run_d = 1'b0;
      end
      default: begin
        txn     = 1'b0;
        state_d = ERR;
      end
    endcase

    if (txn) begin
      spi_rd = issue_q & txn_rd;
      spi_wr = issue_q & ~txn_rd;
      // cnt counts cycles elapsed since the ISSUE cycle; done on the last one still wins.
      if (issue_q) begin
        cnt_d = 32'd1;
      end else if (spi_done) begin
        state_d = nxt;
        issue_d = (nxt == WR4) || (nxt == RDID) || (nxt == RDY) || (nxt == RDZ);
        case (state_q)
          RDID: begin
            if (nxt == IDLE) begin
              cfg_d     = 1'b1;
              per_run_d = 1'b1;
              per_d     = 32'd0;
            end else begin
              id_err_d = 1'b1;
            end
          end
          RDX:     shx_d = rx_swap;
          RDY:     shy_d = rx_swap;
          RDZ:     shz_d = rx_swap;
          default: ;
        endcase
      end else if (cnt_q == 32'(TIMEOUT - 1)) begin
        tmo_err_d = 1'b1;
        cfg_d     = 1'b0;
        state_d   = ERR;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= BOOT;
      issue_q   <= 1'b0;
      cnt_q     <= 32'd0;
      per_q     <= 32'd0;
      per_run_q <= 1'b0;
      shx_q     <= 16'h0;
      shy_q     <= 16'h0;
      shz_q     <= 16'h0;
      x_q       <= 16'h0;
      y_q       <= 16'h0;
      z_q       <= 16'h0;
      sv_q      <= 1'b0;
      cfg_q     <= 1'b0;
      id_err_q  <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      issue_q   <= issue_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      per_run_q <= per_run_d;
      shx_q     <= shx_d;
      shy_q     <= shy_d;
      shz_q     <= shz_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      sv_q      <= sv_d;
      cfg_q     <= cfg_d;
      id_err_q  <= id_err_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign x_out        = x_q;
  assign y_out        = y_q;
  assign z_out        = z_q;
  assign sample_valid = sv_q;
  assign cfg_done     = cfg_q;
  assign id_err       = id_err_q;
  assign timeout_err  = tmo_err_q;
  assign dbg_state_o  = state_q;

endmodule
